// File: rtl/sockit_spi_pkg.sv
// rtl/sockit_spi_pkg.sv - shared types and lane helpers for the sockit SPI slave
package sockit_spi_pkg;

  typedef struct packed {
    logic       pol;
    logic       pha;
    logic [1:0] iom;
    logic       doe;
  } slv_cfg_t;

  typedef enum logic {IDL, ACT} slv_state_t;

  // serial bits carried per sclk period for each lane mode
  function automatic logic [2:0] iom2w(input logic [1:0] iom);
    case (iom)
      2'd2:    iom2w = 3'd2;
      2'd3:    iom2w = 3'd4;
      default: iom2w = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/sockit_spi_slv_if.sv
// rtl/sockit_spi_slv_if.sv - tx (sdw) and rx (sdr) word streams between the SPI slave and the fabric
interface sockit_spi_slv_if #(parameter int DW = 8);
  logic          sdw_vld;
  logic [DW-1:0] sdw_dat;
  logic          sdw_rdy;
  logic          sdr_vld;
  logic [DW-1:0] sdr_dat;
  logic          sdr_rdy;

  modport slave  (input  sdw_vld, sdw_dat, sdr_rdy, output sdw_rdy, sdr_vld, sdr_dat);
  modport master (output sdw_vld, sdw_dat, sdr_rdy, input  sdw_rdy, sdr_vld, sdr_dat);
endinterface

// File: rtl/sockit_spi_sync.sv
// rtl/sockit_spi_sync.sv - N-bit two-flop synchronizer with a selectable reset value
module sockit_spi_sync #(
  parameter int           N  = 1,
  parameter logic [N-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_ff1;
  logic [N-1:0] r_ff2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff1 <= RV;
      r_ff2 <= RV;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/sockit_spi_slv.sv
// rtl/sockit_spi_slv.sv - oversampled SPI slave: 4-wire, 3-wire, dual, quad; CPOL/CPHA 0..3
module sockit_spi_slv
  import sockit_spi_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  slv_cfg_t              i_cfg,
  input  logic                  i_spi_clk,
  input  logic                  i_spi_ssn,
  input  logic [3:0]            i_spi_sio,
  output logic [3:0]            o_spi_sio,
  output logic [3:0]            o_spi_sio_e,
  sockit_spi_slv_if.slave       bus,
  output logic                  o_sts_act,
  output logic                  o_sts_udf,
  output logic                  o_sts_ovf,
  output logic                  o_sts_abt
);

  localparam int CW = $clog2(DW);

  function automatic logic [CW-1:0] f_cnt_max(input logic [1:0] iom);
    case (iom)
      2'd2:    f_cnt_max = CW'(DW / 2 - 1);
      2'd3:    f_cnt_max = CW'(DW / 4 - 1);
      default: f_cnt_max = CW'(DW - 1);
    endcase
  endfunction

  slv_state_t    r_state, w_state_nxt;
  slv_cfg_t      r_cfg;
  logic          r_sclk_d, r_ssn_d, r_lod;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_tx_sr, r_rx_sr, r_sdr_dat;
  logic          r_sdr_vld, r_udf, r_ovf, r_abt;

  logic [5:0]    w_sync;
  logic          w_sclk, w_ssn;
  logic [3:0]    w_sio, w_mask;
  logic          w_ssn_fall, w_ssn_rise, w_start, w_live;
  logic          w_k, w_k_d, w_smp, w_drv, w_load, w_done;
  logic [2:0]    w_w;
  logic [CW-1:0] w_cnt_max;
  logic [DW-1:0] w_rx_nxt;

  // ssn resets high so a reset never looks like a select assertion
  sockit_spi_sync #(.N(6), .RV(6'b010000)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({i_spi_clk, i_spi_ssn, i_spi_sio}),
    .o_q (w_sync)
  );

  assign w_sclk     = w_sync[5];
  assign w_ssn      = w_sync[4];
  assign w_sio      = w_sync[3:0];
  assign w_ssn_fall = r_ssn_d & ~w_ssn;
  assign w_ssn_rise = ~r_ssn_d & w_ssn;
  assign w_start    = (r_state == IDL) && w_ssn_fall;
  assign w_live     = (r_state == ACT) && !w_ssn_rise;

  assign w_k       = w_sclk ^ r_cfg.pol;
  assign w_k_d     = r_sclk_d ^ r_cfg.pol;
  assign w_smp     = w_live && (r_cfg.pha ? (w_k_d & ~w_k) : (w_k & ~w_k_d));
  assign w_drv     = w_live && (r_cfg.pha ? (w_k & ~w_k_d) : (w_k_d & ~w_k));
  assign w_load    = (w_start && !i_cfg.pha) || (w_drv && r_lod);
  assign w_done    = w_smp && (r_cnt == '0);

  assign w_w       = iom2w(r_cfg.iom);
  assign w_cnt_max = f_cnt_max(r_cfg.iom);
  assign w_mask    = (r_cfg.iom == 2'd3) ? 4'hf : (r_cfg.iom == 2'd2) ? 4'h3 : 4'h1;
  assign w_rx_nxt  = (r_rx_sr << w_w) | DW'(w_sio & w_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDL:     if (w_ssn_fall) w_state_nxt = ACT;
      ACT:     if (w_ssn_rise) w_state_nxt = IDL;
      default: w_state_nxt = IDL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg     <= '0;
      r_sclk_d  <= 1'b0;
      r_ssn_d   <= 1'b1;
      r_lod     <= 1'b0;
      r_cnt     <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_sdr_vld <= 1'b0;
      r_sdr_dat <= '0;
      r_udf     <= 1'b0;
      r_ovf     <= 1'b0;
      r_abt     <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk;
      r_ssn_d  <= w_ssn;
      r_udf    <= 1'b0;
      r_ovf    <= 1'b0;
      r_abt    <= 1'b0;

      if (w_start) begin
        r_cfg   <= i_cfg;
        r_cnt   <= f_cnt_max(i_cfg.iom);
        r_lod   <= 1'b1;
        r_rx_sr <= '0;
      end

      // a load at the select edge overrides the lod set just above
      if (w_load) begin
        r_lod   <= 1'b0;
        r_tx_sr <= bus.sdw_vld ? bus.sdw_dat : '1;
        r_udf   <= !bus.sdw_vld;
      end else if (w_drv) begin
        r_tx_sr <= r_tx_sr << w_w;
      end

      if (w_smp) begin
        if (r_cnt != '0) begin
          r_rx_sr <= w_rx_nxt;
          r_cnt   <= r_cnt - 1'b1;
        end else begin
          r_cnt <= w_cnt_max;
          r_lod <= 1'b1;
        end
      end

      if (r_sdr_vld && bus.sdr_rdy) r_sdr_vld <= 1'b0;
      if (w_done) begin
        if (!r_sdr_vld || bus.sdr_rdy) begin
          r_sdr_dat <= w_rx_nxt;
          r_sdr_vld <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end

      if ((r_state == ACT) && w_ssn_rise && ((r_cnt != w_cnt_max) || (!r_lod && r_cfg.pha)))
        r_abt <= 1'b1;
    end
  end

  always_comb begin
    o_spi_sio   = '0;
    o_spi_sio_e = '0;
    if (r_state == ACT) begin
      case (r_cfg.iom)
        2'd0: begin
          o_spi_sio[1] = r_tx_sr[DW-1];
          o_spi_sio_e  = 4'b0010;
        end
        2'd1: begin
          o_spi_sio[0] = r_tx_sr[DW-1];
          o_spi_sio_e  = {3'b000, r_cfg.doe};
        end
        2'd2: begin
          o_spi_sio[1:0] = r_tx_sr[DW-1 -: 2];
          o_spi_sio_e    = {2'b00, {2{r_cfg.doe}}};
        end
        default: begin
          o_spi_sio   = r_tx_sr[DW-1 -: 4];
          o_spi_sio_e = {4{r_cfg.doe}};
        end
      endcase
    end
  end

  assign bus.sdw_rdy = w_load & bus.sdw_vld;
  assign bus.sdr_vld = r_sdr_vld;
  assign bus.sdr_dat = r_sdr_dat;
  assign o_sts_act   = (r_state == ACT);
  assign o_sts_udf   = r_udf;
  assign o_sts_ovf   = r_ovf;
  assign o_sts_abt   = r_abt;

endmodule

// File: tb/tb_sockit_spi_slv.sv
// tb/tb_sockit_spi_slv.sv - bit-banged SPI master against sockit_spi_slv with a word-level model
module tb_sockit_spi_slv;
  import sockit_spi_pkg::*;

  localparam int DW = 8;
  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst;
  slv_cfg_t   cfg;
  logic       sclk, ssn;
  logic [3:0] sio_m, sio_s, sie;
  logic       act, udf, ovf, abt;

  sockit_spi_slv_if #(.DW(DW)) bus ();

  sockit_spi_slv #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cfg       (cfg),
    .i_spi_clk   (sclk),
    .i_spi_ssn   (ssn),
    .i_spi_sio   (sio_m),
    .o_spi_sio   (sio_s),
    .o_spi_sio_e (sie),
    .bus         (bus),
    .o_sts_act   (act),
    .o_sts_udf   (udf),
    .o_sts_ovf   (ovf),
    .o_sts_abt   (abt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int c_rdy = 0, c_udf = 0, c_ovf = 0, c_abt = 0;
  int e_rdy = 0, e_udf = 0, e_ovf = 0, e_abt = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] msrc[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mtx[$];
  logic [DW-1:0] mrd[$];
  logic [3:0]    exp_e = 4'h0;
  logic [DW-1:0] last_sdr = '0;
  bit            m_full = 1'b0;
  bit            rdy_on = 1'b1;
  bit            taken;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lanes(input logic [1:0] iom);
    case (iom)
      2'd0:    lanes = {31'b0, sio_s[1]};
      2'd1:    lanes = {31'b0, sio_s[0]};
      2'd2:    lanes = {30'b0, sio_s[1:0]};
      default: lanes = {28'b0, sio_s};
    endcase
  endfunction

  // word-level model: every load takes a queued tx word or underruns to all ones;
  // a finished rx word lands unless the holding slot is still full
  task automatic m_load();
    if (msrc.size() > 0) begin
      exp_rd.push_back(msrc.pop_front());
      e_rdy++;
    end else begin
      exp_rd.push_back('1);
      e_udf++;
    end
  endtask

  task automatic m_word(input logic [DW-1:0] w);
    if (!m_full) begin
      exp_q.push_back(w);
      if (!rdy_on) m_full = 1'b1;
    end else begin
      e_ovf++;
    end
  endtask

  task automatic give(input logic [DW-1:0] w);
    src_q.push_back(w);
    msrc.push_back(w);
  endtask

  task automatic xfer(input logic [1:0] mode, input logic [1:0] iom, input logic doe, input int abort_slots);
    int w, ns;
    logic pol, pha;
    logic [31:0] tw, rd, bits;
    pol = mode[1];
    pha = mode[0];
    w  = (iom == 2'd3) ? 4 : (iom == 2'd2) ? 2 : 1;
    ns = (abort_slots > 0) ? abort_slots : DW / w;
    cfg = '{pol: pol, pha: pha, iom: iom, doe: doe};
    exp_e = (iom == 2'd0) ? 4'b0010 : !doe ? 4'b0000 :
            (iom == 2'd1) ? 4'b0001 : (iom == 2'd2) ? 4'b0011 : 4'b1111;
    mrd.delete();
    sclk = pol;
    wait_clk(2);
    ssn = 1'b0;
    wait_clk(HP);
    if (!pha) m_load();
    foreach (mtx[i]) begin
      tw = 32'(mtx[i]);
      rd = '0;
      if (pha) m_load();
      if (abort_slots == 0) m_word(mtx[i]);
      for (int s = 0; s < ns; s++) begin
        bits = (tw >> (DW - w * (s + 1))) & ((32'd1 << w) - 1);
        if (!pha) begin
          sio_m = bits[3:0];
          wait_clk(HP);
          sclk = ~pol;
          rd = (rd << w) | lanes(iom);
          wait_clk(HP);
          sclk = pol;
        end else begin
          sclk = ~pol;
          sio_m = bits[3:0];
          wait_clk(HP);
          sclk = pol;
          rd = (rd << w) | lanes(iom);
          wait_clk(HP);
        end
      end
      if (abort_slots > 0) begin
        e_abt++;
      end else begin
        mrd.push_back(rd[DW-1:0]);
        if (!pha) m_load();
      end
    end
    wait_clk(HP);
    ssn = 1'b1;
    wait_clk(2 * HP);
    sio_m = '0;
  endtask

  task automatic check_test(input logic driven);
    if (driven) foreach (mrd[i]) chk("tx_word", 32'(mrd[i]), 32'(exp_rd[i]));
    exp_rd.delete();
    chk("rdy_cnt", c_rdy, e_rdy);
    chk("udf_cnt", c_udf, e_udf);
    chk("ovf_cnt", c_ovf, e_ovf);
    chk("abt_cnt", c_abt, e_abt);
    if (rdy_on) chk("sdr_left", exp_q.size(), 0);
  endtask

  // tx word source: pops a word after each accepted handshake
  initial begin
    bus.sdw_vld = 1'b0;
    bus.sdw_dat = '0;
    forever begin
      @(negedge clk);
      taken = bus.sdw_vld && bus.sdw_rdy;
      @(posedge clk);
      #1;
      if (taken) void'(src_q.pop_front());
      bus.sdw_vld = (src_q.size() > 0);
      bus.sdw_dat = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sdw_rdy) c_rdy++;
      if (udf) c_udf++;
      if (ovf) c_ovf++;
      if (abt) c_abt++;
      chk("sio_e", 32'(sie), act ? 32'(exp_e) : 32'd0);
      if (bus.sdr_vld && bus.sdr_rdy) begin
        if (exp_q.size() == 0) begin
          chk("sdr_extra", exp_q.size(), 1);
        end else begin
          last_sdr = bus.sdr_dat;
          chk("sdr_dat", 32'(bus.sdr_dat), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    cfg = '0;
    sclk = 1'b0;
    ssn = 1'b1;
    sio_m = '0;
    bus.sdr_rdy = 1'b1;
    wait_clk(3);
    chk("rst_outs", {24'b0, bus.sdr_vld, act, udf, ovf, abt, bus.sdw_rdy, |sie, |sio_s}, 32'd0);
    chk("rst_sdr_dat", 32'(bus.sdr_dat), 32'd0);
    rst = 1'b0;
    wait_clk(4);
    chk("idle_act", 32'(act), 32'd0);

    // mode 0, 4-wire
    give(8'hA5);
    mtx = '{8'h3C};
    xfer(2'd0, 2'd0, 1'b0, 0);
    check_test(1'b1);
    chk("t1_rd", 32'(mrd[0]), 32'hA5);
    chk("t1_sdr", 32'(last_sdr), 32'h3C);

    // mode 3, two words under one select
    give(8'h81);
    give(8'h7E);
    mtx = '{8'h12, 8'h34};
    xfer(2'd3, 2'd0, 1'b0, 0);
    check_test(1'b1);
    chk("t2_rd", 32'(mrd[1]), 32'h7E);
    chk("t2_sdr", 32'(last_sdr), 32'h34);

    // underrun
    mtx = '{8'h00};
    xfer(2'd3, 2'd0, 1'b0, 0);
    check_test(1'b1);
    chk("t3_rd", 32'(mrd[0]), 32'hFF);
    chk("t3_sdr", 32'(last_sdr), 32'h00);

    // overflow with the consumer stalled
    rdy_on = 1'b0;
    bus.sdr_rdy = 1'b0;
    mtx = '{8'h11, 8'h22};
    xfer(2'd3, 2'd0, 1'b0, 0);
    check_test(1'b1);
    chk("t4_hold_vld", 32'(bus.sdr_vld), 32'd1);
    chk("t4_hold_dat", 32'(bus.sdr_dat), 32'h11);
    rdy_on = 1'b1;
    m_full = 1'b0;
    bus.sdr_rdy = 1'b1;
    wait_clk(4);
    chk("t4_drain", exp_q.size(), 0);
    chk("t4_sdr", 32'(last_sdr), 32'h11);

    // abort after five bits, then a clean word
    mtx = '{8'hA7};
    xfer(2'd0, 2'd0, 1'b0, 5);
    check_test(1'b0);
    mtx = '{8'h5A};
    xfer(2'd0, 2'd0, 1'b0, 0);
    check_test(1'b1);
    chk("t5_sdr", 32'(last_sdr), 32'h5A);

    // quad, driving then receive-only
    give(8'hC3);
    mtx = '{8'h00};
    xfer(2'd0, 2'd3, 1'b1, 0);
    check_test(1'b1);
    chk("t6_rd", 32'(mrd[0]), 32'hC3);
    mtx = '{8'h96};
    xfer(2'd0, 2'd3, 1'b0, 0);
    check_test(1'b0);
    chk("t6_sdr", 32'(last_sdr), 32'h96);

    // dual mode 1 and 3-wire mode 2
    give(8'h4B);
    mtx = '{8'hE1};
    xfer(2'd1, 2'd2, 1'b1, 0);
    check_test(1'b1);
    chk("t7_rd", 32'(mrd[0]), 32'h4B);
    chk("t7_sdr", 32'(last_sdr), 32'hE1);

    give(8'h6D);
    mtx = '{8'h92};
    xfer(2'd2, 2'd1, 1'b1, 0);
    check_test(1'b1);
    chk("t8_rd", 32'(mrd[0]), 32'h6D);
    chk("t8_sdr", 32'(last_sdr), 32'h92);

    wait_clk(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
